multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle decode with a Moore-style state machine that drives the shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps. It honours a ready handshake from the unified instruction/data memory. Memory-gated enables are Mealy on `mem_ready`. It sits between the instruction register opcode field and every datapath mux/enable.

## Interface
- `TRAP_ON_ILLEGAL`, default 1: 1 = illegal opcode enters sticky TRAP; 0 = illegal opcode treated as NOP (return to FETCH).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high. Clears state to FETCH.
- `OpCode` in 6: IR[31:26], valid from DECODE onward.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond` out 1: unconditional / branch PC write.
- `pc_en` out 1: `PCWrite | (PCWriteCond & Zero)`.
- `IorD` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`, `IRWrite`, `RegWrite` out 1.
- `MemToReg` out 2: write data select. 00 = ALUOut, 01 = MDR, 10 = PC.
- `RegDst` out 2: destination select. 00 = rt, 01 = rd, 10 = 31.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = funct, 11 = immediate-logic/LUI.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` out 4: current state code, for debug.
- `illegal` out 1: high in TRAP.

## Operation
- Opcodes: R 0x00, J 0x02, JAL 0x03, BEQ 0x04, ADDI 0x08, ADDIU 0x09, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B.
- Every unlisted output is 0 in every state.
- States and their asserted outputs:
  - FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite are asserted only when `mem_ready`=1. Stays in FETCH while `mem_ready`=0.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
    - LW/SW → MEM_ADDR
    - R → R_EXEC
    - BEQ → BRANCH
    - J → JUMP
    - JAL → JAL
    - ADDI/ADDIU/ORI/LUI → I_EXEC
    - other → TRAP, or FETCH when `TRAP_ON_ILLEGAL`=0
  - MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEM_READ for LW, MEM_WRITE for SW.
  - MEM_READ (3): MemRead=1, IorD=1. Waits for `mem_ready`, then → MEM_WB.
  - MEM_WB (4): RegWrite=1, RegDst=00, MemToReg=01. → FETCH.
  - MEM_WRITE (5): MemWrite=1, IorD=1. Waits for `mem_ready`, then → FETCH.
  - R_EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. → R_WB.
  - R_WB (7): RegWrite=1, RegDst=01, MemToReg=00. → FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. → FETCH.
  - JUMP (9): PCWrite=1, PCSource=10. → FETCH.
  - I_EXEC (10): ALUSrcA=1, ALUSrcB=10. ALUOp=11 for ORI/LUI, 00 for ADDI/ADDIU. → I_WB.
  - I_WB (11): RegWrite=1, RegDst=00, MemToReg=00. Holds I_EXEC's ALUOp. → FETCH.
  - JAL (12): PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemToReg=10. $31 receives the PC+4 value written back in FETCH. → FETCH.
  - TRAP (13): `illegal`=1, all enables 0. Leaves TRAP only on reset.
- Codes 14 and 15 are unreachable. If they are ever entered, the next state is FETCH with all outputs 0.

## Timing
- Reset: while `reset`=1, state=FETCH (0) and every output is 0, including MemRead, `pc_en` and `illegal`. Outputs are forced low combinationally, not just at the next edge.
- Reset mid-access: an in-flight MEM_WRITE or MEM_READ is abandoned and MemWrite drops immediately. The first cycle after release is FETCH.
- The transition decision is registered on the rising edge.
- `mem_ready` is sampled only in FETCH, MEM_READ and MEM_WRITE, and ignored elsewhere.
- While waiting, IorD, MemRead/MemWrite and the ALU selects hold steady.
- `OpCode` changes are ignored outside DECODE and I_EXEC/I_WB.
- Cycles per instruction with `mem_ready` tied to 1: R 4, LW 5, SW 4, BEQ 3, J 3, JAL 3, I-type 4. Each wait cycle on `mem_ready` adds one cycle.
- `pc_en` is combinational with respect to `Zero` in BRANCH.

## Test plan
- R-type, `mem_ready`=1: states 0→1→6→7→0. RegWrite=1 and RegDst=01 only in state 7. 4 cycles total.
- LW with `mem_ready` low for 2 cycles in MEM_READ: state 3 holds for 3 cycles with MemRead=1, IorD=1. Then MEM_WB with MemToReg=01. 7 cycles total.
- BEQ: `Zero`=1 gives `pc_en`=1 in state 8. `Zero`=0 gives `pc_en`=0 and PCSource=01. Both cases return to FETCH.
- JAL: in state 12, RegDst=10, MemToReg=10, RegWrite=1, PCWrite=1, PCSource=10. Next state 0.
- Opcode 0x3F:
  - `TRAP_ON_ILLEGAL`=1: state 13, `illegal`=1, stays for 20 cycles with all enables 0. Reset returns to state 0.
  - `TRAP_ON_ILLEGAL`=0: DECODE→FETCH, `illegal`=0.
- Assert `reset` asynchronously mid-MEM_WRITE (SW, `mem_ready`=0): MemWrite falls before the next edge and all outputs are 0. After release, FETCH with MemRead=1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: walks fetch/decode/execute/memory/writeback
// and drives every datapath mux and enable, with Mealy memory-gated fetch writes.
module multicycle_control #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       pc_en,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] MemToReg,
    output logic [1:0] RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11,
        JAL       = 4'd12,
        TRAP      = 4'd13
    } stateT;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic [1:0] memToReg;
        logic [1:0] regDst;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       illegal;
    } ctrlT;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam ctrlT FETCH_CTRL = '{memRead: 1'b1, aluSrcB: 2'b01, default: '0};

    stateT curState;
    stateT nextState;
    ctrlT  ctrlQ;
    ctrlT  ctrlNext;
    logic  storeQ;
    logic  storeNext;
    logic  iLogicQ;
    logic  iLogicNext;
    logic  live;
    logic  inFetch;

    // Next-state decision; the opcode is only looked at in DECODE, where the
    // load/store choice and the I-type ALU flavour are captured for later steps.
    always_comb begin
        nextState  = FETCH;
        storeNext  = storeQ;
        iLogicNext = iLogicQ;
        case (curState)
            FETCH:     nextState = mem_ready ? DECODE : FETCH;
            DECODE: begin
                storeNext  = (OpCode == OP_SW);
                iLogicNext = (OpCode == OP_ORI) || (OpCode == OP_LUI);
                case (OpCode)
                    OP_LW, OP_SW:                      nextState = MEM_ADDR;
                    OP_R:                              nextState = R_EXEC;
                    OP_BEQ:                            nextState = BRANCH;
                    OP_J:                              nextState = JUMP;
                    OP_JAL:                            nextState = JAL;
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: nextState = I_EXEC;
                    default:                           nextState = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                endcase
            end
            MEM_ADDR:  nextState = storeQ ? MEM_WRITE : MEM_READ;
            MEM_READ:  nextState = mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    nextState = FETCH;
            MEM_WRITE: nextState = mem_ready ? FETCH : MEM_WRITE;
            R_EXEC:    nextState = R_WB;
            R_WB:      nextState = FETCH;
            BRANCH:    nextState = FETCH;
            JUMP:      nextState = FETCH;
            I_EXEC:    nextState = I_WB;
            I_WB:      nextState = FETCH;
            JAL:       nextState = FETCH;
            TRAP:      nextState = TRAP;
            default:   nextState = FETCH;
        endcase
    end

    // Control word for the state being entered, so the outputs come straight off flops.
    always_comb begin
        ctrlNext = '0;
        case (nextState)
            FETCH:     ctrlNext = FETCH_CTRL;
            DECODE:    ctrlNext.aluSrcB = 2'b11;
            MEM_ADDR: begin
                ctrlNext.aluSrcA = 1'b1;
                ctrlNext.aluSrcB = 2'b10;
            end
            MEM_READ: begin
                ctrlNext.memRead = 1'b1;
                ctrlNext.iorD    = 1'b1;
            end
            MEM_WB: begin
                ctrlNext.regWrite = 1'b1;
                ctrlNext.memToReg = 2'b01;
            end
            MEM_WRITE: begin
                ctrlNext.memWrite = 1'b1;
                ctrlNext.iorD     = 1'b1;
            end
            R_EXEC: begin
                ctrlNext.aluSrcA = 1'b1;
                ctrlNext.aluOp   = 2'b10;
            end
            R_WB: begin
                ctrlNext.regWrite = 1'b1;
                ctrlNext.regDst   = 2'b01;
            end
            BRANCH: begin
                ctrlNext.aluSrcA     = 1'b1;
                ctrlNext.aluOp       = 2'b01;
                ctrlNext.pcWriteCond = 1'b1;
                ctrlNext.pcSource    = 2'b01;
            end
            JUMP: begin
                ctrlNext.pcWrite  = 1'b1;
                ctrlNext.pcSource = 2'b10;
            end
            I_EXEC: begin
                ctrlNext.aluSrcA = 1'b1;
                ctrlNext.aluSrcB = 2'b10;
                ctrlNext.aluOp   = iLogicNext ? 2'b11 : 2'b00;
            end
            I_WB: begin
                ctrlNext.regWrite = 1'b1;
                ctrlNext.aluOp    = iLogicNext ? 2'b11 : 2'b00;
            end
            JAL: begin
                ctrlNext.pcWrite  = 1'b1;
                ctrlNext.pcSource = 2'b10;
                ctrlNext.regWrite = 1'b1;
                ctrlNext.regDst   = 2'b10;
                ctrlNext.memToReg = 2'b10;
            end
            TRAP:      ctrlNext.illegal = 1'b1;
            default:   ctrlNext = '0;
        endcase
    end

    // State and registered control word; reset lands in FETCH with its controls ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curState <= FETCH;
            ctrlQ    <= FETCH_CTRL;
            storeQ   <= 1'b0;
            iLogicQ  <= 1'b0;
        end else begin
            curState <= nextState;
            ctrlQ    <= ctrlNext;
            storeQ   <= storeNext;
            iLogicQ  <= iLogicNext;
        end
    end

    // Reset and the two unused codes force every output low without waiting for an edge.
    assign live    = ~reset && (curState <= TRAP);
    assign inFetch = (curState == FETCH);

    assign PCWrite     = live & (ctrlQ.pcWrite | (inFetch & mem_ready));
    assign IRWrite     = live & inFetch & mem_ready;
    assign PCWriteCond = live & ctrlQ.pcWriteCond;
    assign pc_en       = PCWrite | (PCWriteCond & Zero);
    assign IorD        = live & ctrlQ.iorD;
    assign MemRead     = live & ctrlQ.memRead;
    assign MemWrite    = live & ctrlQ.memWrite;
    assign RegWrite    = live & ctrlQ.regWrite;
    assign MemToReg    = {2{live}} & ctrlQ.memToReg;
    assign RegDst      = {2{live}} & ctrlQ.regDst;
    assign ALUSrcA     = live & ctrlQ.aluSrcA;
    assign ALUSrcB     = {2{live}} & ctrlQ.aluSrcB;
    assign ALUOp       = {2{live}} & ctrlQ.aluOp;
    assign PCSource    = {2{live}} & ctrlQ.pcSource;
    assign illegal     = live & ctrlQ.illegal;
    assign state       = curState;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (trap on / trap off) checked every cycle
// against an instruction-path model, plus directed sequences pinned with literal values.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode;
    logic       Zero;
    logic       mem_ready;

    logic [1:0] pcWriteV, pcWriteCondV, pcEnV, iorDV, memReadV, memWriteV, irWriteV;
    logic [1:0] regWriteV, aluSrcAV, illegalV;
    logic [1:0] memToRegV [2];
    logic [1:0] regDstV   [2];
    logic [1:0] aluSrcBV  [2];
    logic [1:0] aluOpV    [2];
    logic [1:0] pcSourceV [2];
    logic [3:0] stateV    [2];
    logic [23:0] obs      [2];

    int compared = 0;
    int failed   = 0;

    // Model: each instance walks the list of states its decoded instruction needs.
    int mState  [2];
    bit mILogic [2];
    int path    [2][4];
    int pathLen [2];
    int pathPos [2];

    logic [23:0] lastObs  [2];
    logic [23:0] pulseObs [2];

    logic [5:0] legalOps [10] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    int  lwStates [7] = '{0, 1, 2, 3, 3, 3, 4};
    bit  lwReady  [7] = '{1, 1, 1, 0, 0, 1, 1};
    int  rStates  [4] = '{0, 1, 6, 7};

    always #5 clk = ~clk;

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(pcWriteV[0]), .PCWriteCond(pcWriteCondV[0]), .pc_en(pcEnV[0]),
        .IorD(iorDV[0]), .MemRead(memReadV[0]), .MemWrite(memWriteV[0]),
        .IRWrite(irWriteV[0]), .RegWrite(regWriteV[0]), .MemToReg(memToRegV[0]),
        .RegDst(regDstV[0]), .ALUSrcA(aluSrcAV[0]), .ALUSrcB(aluSrcBV[0]),
        .ALUOp(aluOpV[0]), .PCSource(pcSourceV[0]), .state(stateV[0]), .illegal(illegalV[0])
    );

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(pcWriteV[1]), .PCWriteCond(pcWriteCondV[1]), .pc_en(pcEnV[1]),
        .IorD(iorDV[1]), .MemRead(memReadV[1]), .MemWrite(memWriteV[1]),
        .IRWrite(irWriteV[1]), .RegWrite(regWriteV[1]), .MemToReg(memToRegV[1]),
        .RegDst(regDstV[1]), .ALUSrcA(aluSrcAV[1]), .ALUSrcB(aluSrcBV[1]),
        .ALUOp(aluOpV[1]), .PCSource(pcSourceV[1]), .state(stateV[1]), .illegal(illegalV[1])
    );

    assign obs[0] = {stateV[0], pcWriteV[0], pcWriteCondV[0], pcEnV[0], iorDV[0], memReadV[0],
                     memWriteV[0], irWriteV[0], regWriteV[0], memToRegV[0], regDstV[0],
                     aluSrcAV[0], aluSrcBV[0], aluOpV[0], pcSourceV[0], illegalV[0]};
    assign obs[1] = {stateV[1], pcWriteV[1], pcWriteCondV[1], pcEnV[1], iorDV[1], memReadV[1],
                     memWriteV[1], irWriteV[1], regWriteV[1], memToRegV[1], regDstV[1],
                     aluSrcAV[1], aluSrcBV[1], aluOpV[1], pcSourceV[1], illegalV[1]};

    // Output table straight from the state descriptions, packed like obs[].
    function automatic logic [23:0] expOut(input int st, input bit iLogic, input logic mr,
                                           input logic z, input logic rst);
        logic [3:0] s;
        logic pw, pwc, pe, iod, mrd, mwr, irw, rw, asa, ill;
        logic [1:0] m2r, rd, asb, aop, psrc;
        s = 4'(st);
        {pw, pwc, pe, iod, mrd, mwr, irw, rw, asa, ill} = '0;
        {m2r, rd, asb, aop, psrc} = '0;
        if (rst) begin
            s = 4'd0;
        end else begin
            case (st)
                0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
                1:  asb = 2'b11;
                2:  begin asa = 1; asb = 2'b10; end
                3:  begin mrd = 1; iod = 1; end
                4:  begin rw = 1; m2r = 2'b01; end
                5:  begin mwr = 1; iod = 1; end
                6:  begin asa = 1; aop = 2'b10; end
                7:  begin rw = 1; rd = 2'b01; end
                8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
                9:  begin pw = 1; psrc = 2'b10; end
                10: begin asa = 1; asb = 2'b10; aop = iLogic ? 2'b11 : 2'b00; end
                11: begin rw = 1; aop = iLogic ? 2'b11 : 2'b00; end
                12: begin pw = 1; psrc = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
                13: ill = 1;
                default: ;
            endcase
            pe = pw | (pwc & z);
        end
        return {s, pw, pwc, pe, iod, mrd, mwr, irw, rw, m2r, rd, asa, asb, aop, psrc, ill};
    endfunction

    task automatic setPath(input int i, input int a, input int b, input int c, input int n);
        path[i][0] = a;
        path[i][1] = b;
        path[i][2] = c;
        pathLen[i] = n;
        pathPos[i] = 0;
    endtask

    task automatic advance(input int i);
        if (pathPos[i] < pathLen[i]) begin
            mState[i] = path[i][pathPos[i]];
            pathPos[i]++;
        end else begin
            mState[i] = 0;
        end
    endtask

    task automatic stepModel(input int i, input logic [5:0] op, input logic mr,
                             input logic rst, input bit trapOn);
        if (rst) begin
            mState[i] = 0;
            setPath(i, 0, 0, 0, 0);
        end else if (mState[i] == 0) begin
            if (mr) mState[i] = 1;
        end else if (mState[i] == 1) begin
            mILogic[i] = (op == 6'h0D) || (op == 6'h0F);
            case (op)
                6'h00:                      setPath(i, 6, 7, 0, 2);
                6'h02:                      setPath(i, 9, 0, 0, 1);
                6'h03:                      setPath(i, 12, 0, 0, 1);
                6'h04:                      setPath(i, 8, 0, 0, 1);
                6'h08, 6'h09, 6'h0D, 6'h0F: setPath(i, 10, 11, 0, 2);
                6'h23:                      setPath(i, 2, 3, 4, 3);
                6'h2B:                      setPath(i, 2, 5, 0, 2);
                default: begin
                    if (trapOn) setPath(i, 13, 0, 0, 1);
                    else        setPath(i, 0, 0, 0, 0);
                end
            endcase
            advance(i);
        end else if (mState[i] == 13) begin
            mState[i] = 13;
        end else if ((mState[i] == 3 || mState[i] == 5) && !mr) begin
            mState[i] = mState[i];
        end else begin
            advance(i);
        end
    endtask

    task automatic checkOutput(input bit pulseSample);
        logic [23:0] exp;
        for (int i = 0; i < 2; i++) begin
            exp = expOut(mState[i], mILogic[i], mem_ready, Zero, reset);
            compared++;
            if (obs[i] !== exp) begin
                failed++;
                $display("[TB] FAIL outputs dut%0d t=%0t: actual %h required %h", i, $time, obs[i], exp);
            end
            if (pulseSample) pulseObs[i] = obs[i];
            else             lastObs[i]  = obs[i];
        end
    endtask

    task automatic checkLit(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s t=%0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    // One clock: drive at +1 after the edge, check on the falling edge, optionally
    // pulse reset asynchronously mid-cycle, then advance the model on the next edge.
    task automatic applyStimulus(input logic mr, input logic z, input logic [5:0] op,
                                 input logic rst, input bit pulse);
        mem_ready = mr;
        Zero      = z;
        OpCode    = op;
        reset     = rst;
        @(negedge clk);
        checkOutput(1'b0);
        if (pulse) begin
            #1 reset = 1'b1;
            #1 checkOutput(1'b1);
        end
        @(posedge clk);
        stepModel(0, OpCode, mem_ready, reset, 1'b0);
        stepModel(1, OpCode, mem_ready, reset, 1'b1);
        #1;
    endtask

    initial begin
        logic [5:0] op;
        int trapCnt;
        bit pulse;
        for (int i = 0; i < 2; i++) begin
            mState[i]  = 0;
            mILogic[i] = 0;
            setPath(i, 0, 0, 0, 0);
        end
        reset = 1'b1; OpCode = '0; Zero = 1'b0; mem_ready = 1'b1;
        #1;

        applyStimulus(1, 0, 6'h00, 1, 0);
        checkLit("resetState", 8'(lastObs[1][23:20]), 8'd0);
        checkLit("resetMemRead", 8'(lastObs[1][15]), 8'd0);
        checkLit("resetPcEn", 8'(lastObs[1][17]), 8'd0);
        applyStimulus(1, 0, 6'h00, 1, 0);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 6'h00, 0, 0);
            checkLit("rSeqState", 8'(lastObs[1][23:20]), 8'(rStates[k]));
            checkLit("rRegWrite", 8'(lastObs[1][12]), (k == 3) ? 8'd1 : 8'd0);
        end
        checkLit("rRegDst", 8'(lastObs[1][9:8]), 8'd1);

        for (int k = 0; k < 7; k++) begin
            applyStimulus(lwReady[k], 0, 6'h23, 0, 0);
            checkLit("lwSeqState", 8'(lastObs[1][23:20]), 8'(lwStates[k]));
            if (lwStates[k] == 3) checkLit("lwMemReadIorD", 8'({lastObs[1][16], lastObs[1][15]}), 8'd3);
        end
        checkLit("lwMemToReg", 8'(lastObs[1][11:10]), 8'd1);

        for (int zz = 1; zz >= 0; zz--) begin
            for (int k = 0; k < 3; k++) applyStimulus(1, 1'(zz), 6'h04, 0, 0);
            checkLit("beqState", 8'(lastObs[1][23:20]), 8'd8);
            checkLit("beqPcEn", 8'(lastObs[1][17]), 8'(zz));
            checkLit("beqPcSource", 8'(lastObs[1][2:1]), 8'd1);
        end

        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 6'h03, 0, 0);
        checkLit("jalState", 8'(lastObs[1][23:20]), 8'd12);
        checkLit("jalFields", 8'({lastObs[1][19], lastObs[1][12], lastObs[1][11:10], lastObs[1][9:8], lastObs[1][2:1]}),
                 8'b1_1_10_10_10);

        applyStimulus(1, 0, 6'h3F, 0, 0);
        checkLit("jalNextFetch", 8'(lastObs[1][23:20]), 8'd0);
        applyStimulus(1, 0, 6'h3F, 0, 0);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 1, 6'h3F, 0, 0);
            checkLit("trapState", 8'(lastObs[1][23:20]), 8'd13);
            checkLit("trapIllegal", 8'(lastObs[1][0]), 8'd1);
            checkLit("trapEnables", lastObs[1][19:12], 8'd0);
            if (k == 0) begin
                checkLit("noTrapState", 8'(lastObs[0][23:20]), 8'd0);
                checkLit("noTrapIllegal", 8'(lastObs[0][0]), 8'd0);
            end
        end
        applyStimulus(1, 0, 6'h3F, 1, 0);
        checkLit("trapResetState", 8'(lastObs[1][23:20]), 8'd0);

        applyStimulus(1, 0, 6'h2B, 0, 0);
        applyStimulus(1, 0, 6'h2B, 0, 0);
        applyStimulus(1, 0, 6'h2B, 0, 0);
        applyStimulus(0, 0, 6'h2B, 0, 1);
        checkLit("swMemWrite", 8'(lastObs[1][14]), 8'd1);
        checkLit("swResetAll", 8'(pulseObs[1] == 24'd0), 8'd1);
        applyStimulus(0, 0, 6'h2B, 0, 0);
        checkLit("swReleaseFetch", 8'({lastObs[1][23:20], lastObs[1][15]}), 8'b0000_1);

        trapCnt = 0;
        op = 6'h00;
        for (int n = 0; n < 3000; n++) begin
            if ((mState[0] == 0 || mState[0] == 13) && (mState[1] == 0 || mState[1] == 13))
                op = ($urandom % 8 != 0) ? legalOps[$urandom % 10] : 6'($urandom);
            trapCnt = (mState[1] == 13) ? trapCnt + 1 : 0;
            pulse = (trapCnt >= 5) || ($urandom % 100 == 0);
            applyStimulus(1'($urandom % 4 != 0), 1'($urandom), op, 0, pulse);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
